board_scanner: RTL and testbench

//  Consumer end of the board generator's fresh/if_generated handshake. On start it requests a
//  new 8x8 board, latches the 192-bit board, then scans it cell by cell for runs of >=3 equal
//  non-empty colours, horizontal or vertical. It reports a 64-bit match mask and a match count
//  to game logic. The same mask drives the elimination and refill decision.

---
 rtl/board_scanner_pkg.sv | 21 ++
 rtl/board_scanner_popcount.sv | 23 ++
 rtl/board_scanner.sv | 124 ++++++++++++
 tb/tb_board_scanner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/board_scanner_pkg.sv
// Shared board geometry, FSM states and cell access for the board scanner.
package board_scanner_pkg;
  localparam int BOARD_N = 8;
  localparam int CELL_W  = 3;
  localparam int CELLS   = BOARD_N * BOARD_N;
  localparam int BOARD_W = CELLS * CELL_W;
  localparam logic [CELL_W-1:0] COLOR_EMPTY = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_SCAN  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Cell i = 8*r+c of a flat board vector.
  function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b, input logic [5:0] i);
    return b[i*CELL_W +: CELL_W];
  endfunction
endpackage

// File: rtl/board_scanner_popcount.sv
// 64-bit population count built from eight byte-lane partial counts.
module popcount64 (
  input  logic [63:0] i_vec,
  output logic [6:0]  o_cnt
);
  function automatic logic [3:0] lane_cnt(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) s = s + {3'd0, v[b]};
    return s;
  endfunction

  logic [7:0][3:0] w_lane;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign w_lane[g] = lane_cnt(i_vec[8*g +: 8]);
  end

  always_comb begin
    o_cnt = '0;
    for (int g = 0; g < 8; g++) o_cnt = o_cnt + {3'd0, w_lane[g]};
  end
endmodule

// File: rtl/board_scanner.sv
// Requests a board from the generator, scans one cell per cycle for runs >=3,
// then reports the match mask, its popcount and a timeout error flag.
module board_scanner
  import board_scanner_pkg::*;
#(
  parameter int GEN_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               ack,
  output logic               fresh,
  input  logic               if_generated,
  input  logic [BOARD_W-1:0] new_board,
  output logic [BOARD_W-1:0] board_q,
  output logic [CELLS-1:0]   match_mask,
  output logic [6:0]         match_count,
  output logic               has_match,
  output logic               done,
  output logic               err
);
  localparam logic [7:0] TMO = 8'(GEN_TIMEOUT);

  state_t             r_state, w_next;
  logic [5:0]         r_idx;
  logic [7:0]         r_tcnt;
  logic               r_fresh, r_done, r_err, r_has;
  logic [BOARD_W-1:0] r_board;
  logic [CELLS-1:0]   r_mask, w_set;
  logic [6:0]         r_cnt, w_pop;
  logic [2:0]         w_r, w_c;
  logic [CELL_W-1:0]  w_v;
  logic               w_h_hit, w_v_hit;

  // Window compares; c<=5 / r<=5 guards keep runs from wrapping across edges.
  assign w_r = r_idx[5:3];
  assign w_c = r_idx[2:0];
  assign w_v = cell_at(r_board, r_idx);
  assign w_h_hit = (w_c <= 3'd5) && (w_v != COLOR_EMPTY) &&
                   (w_v == cell_at(r_board, r_idx + 6'd1)) &&
                   (w_v == cell_at(r_board, r_idx + 6'd2));
  assign w_v_hit = (w_r <= 3'd5) && (w_v != COLOR_EMPTY) &&
                   (w_v == cell_at(r_board, r_idx + 6'd8)) &&
                   (w_v == cell_at(r_board, r_idx + 6'd16));
  assign w_set = (w_h_hit ? (64'h7 << r_idx) : '0) |
                 (w_v_hit ? (64'h10101 << r_idx) : '0);

  popcount64 u_pop (.i_vec(r_mask), .o_cnt(w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_REQ;
      S_REQ:   if (if_generated)   w_next = S_SCAN;
               else if (r_tcnt == TMO) w_next = S_DONE;
      S_SCAN:  if (r_idx == 6'd63) w_next = S_COUNT;
      S_COUNT: w_next = S_DONE;
      S_DONE:  if (ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fresh <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_has   <= 1'b0;
      r_board <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_fresh <= 1'b1;
          r_mask  <= '0;
          r_err   <= 1'b0;
          r_tcnt  <= '0;
        end
        S_REQ: begin
          if (if_generated) begin
            r_board <= new_board;
            r_idx   <= '0;
            r_fresh <= 1'b0;
          end else if (r_tcnt == TMO) begin
            r_err   <= 1'b1;
            r_fresh <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_has   <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_SCAN: begin
          r_mask <= r_mask | w_set;
          if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
        end
        S_COUNT: begin
          r_cnt  <= w_pop;
          r_has  <= |r_mask;
          r_done <= 1'b1;
        end
        S_DONE: if (ack) r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign fresh       = r_fresh;
  assign done        = r_done;
  assign err         = r_err;
  assign has_match   = r_has;
  assign board_q     = r_board;
  assign match_mask  = r_mask;
  assign match_count = r_cnt;
endmodule

// File: tb/tb_board_scanner.sv
// Directed table, random boards against a run-length reference model, and
// hand-written timeout / mid-scan reset / ack+start sequences.
module tb_board_scanner;
  import board_scanner_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ack = 1'b0;
  logic         if_generated = 1'b0;
  logic [191:0] new_board = '0;
  logic         fresh, has_match, done, err;
  logic [191:0] board_q;
  logic [63:0]  match_mask;
  logic [6:0]   match_count;

  int checks = 0;
  int errors = 0;

  board_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ack(ack), .fresh(fresh),
    .if_generated(if_generated), .new_board(new_board), .board_q(board_q),
    .match_mask(match_mask), .match_count(match_count), .has_match(has_match),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [191:0] board;
    logic [63:0]  mask;
    logic [6:0]   cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [191:0] put(input logic [191:0] b, input int r, input int c, input int v);
    b[(8*r+c)*3 +: 3] = 3'(v);
    return b;
  endfunction

  function automatic logic [191:0] checker_board();
    logic [191:0] b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b = put(b, r, c, ((r + c) % 2) + 1);
    return b;
  endfunction

  // Reference: maximal equal-colour runs along each row and column.
  function automatic logic [63:0] model_mask(input logic [191:0] b);
    int g[8][8];
    logic [63:0] m = '0;
    int s, k;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g[r][c] = int'(b[(8*r+c)*3 +: 3]);
    for (int r = 0; r < 8; r++) begin
      k = 0;
      while (k < 8) begin
        s = k;
        while (k < 8 && g[r][k] == g[r][s]) k++;
        if (g[r][s] != 0 && k - s >= 3)
          for (int j = s; j < k; j++) m[8*r+j] = 1'b1;
      end
    end
    for (int c = 0; c < 8; c++) begin
      k = 0;
      while (k < 8) begin
        s = k;
        while (k < 8 && g[k][c] == g[s][c]) k++;
        if (g[s][c] != 0 && k - s >= 3)
          for (int j = s; j < k; j++) m[8*j+c] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic start_and_latch(input logic [191:0] b);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("fresh_after_start", 192'(fresh), 192'(1));
    new_board = b; if_generated = 1'b1;
    @(negedge clk); if_generated = 1'b0; new_board = '0;
  endtask

  task automatic run_scan(input string tag, input logic [191:0] b, input logic [63:0] em,
                          input logic [6:0] ec, input bit do_ack);
    int lat = 999;
    start_and_latch(b);
    check({tag, "_fresh_dropped"}, 192'(fresh), 192'(0));
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    check({tag, "_latency"}, 192'(lat), 192'(65));
    check({tag, "_mask"}, 192'(match_mask), 192'(em));
    check({tag, "_count"}, 192'(match_count), 192'(ec));
    check({tag, "_has_match"}, 192'(has_match), 192'(em != 0));
    check({tag, "_err"}, 192'(err), 192'(0));
    check({tag, "_board_q"}, board_q, b);
    if (do_ack) begin
      @(negedge clk); ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      check({tag, "_done_cleared"}, 192'(done), 192'(0));
    end
  endtask

  initial begin
    logic [191:0] b, base;
    logic [63:0]  m;
    int lat;

    // Reset state
    #1;
    check("rst_fresh", 192'(fresh), 192'(0));
    check("rst_done", 192'(done), 192'(0));
    check("rst_err", 192'(err), 192'(0));
    check("rst_mask", 192'(match_mask), 192'(0));
    check("rst_count", 192'(match_count), 192'(0));
    check("rst_has", 192'(has_match), 192'(0));
    check("rst_board", board_q, 192'(0));
    @(negedge clk); rst_n = 1'b1;

    base = checker_board();
    vecs.push_back('{base, 64'h0, 7'd0});
    b = base; for (int c = 0; c < 4; c++) b = put(b, 0, c, 3);
    vecs.push_back('{b, 64'h0000_0000_0000_000F, 7'd4});
    b = base;
    for (int c = 2; c <= 4; c++) b = put(b, 2, c, 5);
    for (int r = 2; r <= 4; r++) b = put(b, r, 3, 5);
    vecs.push_back('{b, 64'h0000_0008_081C_0000, 7'd5});
    b = base; for (int r = 5; r < 8; r++) b = put(b, r, 7, 4);
    vecs.push_back('{b, 64'h8080_8000_0000_0000, 7'd3});
    b = base; for (int c = 5; c < 8; c++) b = put(b, 7, c, 7);
    vecs.push_back('{b, 64'hE000_0000_0000_0000, 7'd3});
    b = '0; for (int i = 0; i < 64; i++) b = put(b, i / 8, i % 8, 5);
    vecs.push_back('{b, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64});
    vecs.push_back('{192'(0), 64'h0, 7'd0});

    foreach (vecs[i]) run_scan($sformatf("vec%0d", i), vecs[i].board, vecs[i].mask, vecs[i].cnt, 1'b1);

    // Random boards: generator-like colours 1..5 and the full 0..7 range
    for (int t = 0; t < 24; t++) begin
      b = '0;
      for (int i = 0; i < 64; i++)
        b = put(b, i / 8, i % 8, (t % 2 == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 7)));
      m = model_mask(b);
      run_scan($sformatf("rnd%0d", t), b, m, 7'($countones(m)), 1'b1);
    end

    // Generator never answers
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("tmo_fresh_high", 192'(fresh), 192'(1));
    lat = 999;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    check("tmo_latency_window", 192'(lat >= 255 && lat <= 256), 192'(1));
    check("tmo_err", 192'(err), 192'(1));
    check("tmo_fresh_low", 192'(fresh), 192'(0));
    check("tmo_mask", 192'(match_mask), 192'(0));
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    check("tmo_done_cleared", 192'(done), 192'(0));

    // Reset mid-scan at idx 30, after the row-0 run has already hit the mask
    start_and_latch(vecs[1].board);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mask", 192'(match_mask), 192'(0));
    check("mid_rst_board", board_q, 192'(0));
    check("mid_rst_done", 192'(done), 192'(0));
    check("mid_rst_fresh", 192'(fresh), 192'(0));
    check("mid_rst_count", 192'(match_count), 192'(0));
    @(negedge clk); rst_n = 1'b1;
    run_scan("post_rst", vecs[2].board, vecs[2].mask, vecs[2].cnt, 1'b0);

    // ack and start together in DONE: return to IDLE without a new request
    @(negedge clk); ack = 1'b1; start = 1'b1;
    @(negedge clk); ack = 1'b0; start = 1'b0;
    check("ackstart_done", 192'(done), 192'(0));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("ackstart_nofresh%0d", n), 192'(fresh), 192'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
